// File: rtl/k12a_spi_target_if.sv
// rtl/k12a_spi_target_if.sv - pin and byte-stream bundle for the k12a SPI target
// Ports (slave modport = the target itself):
//   SPI pins     spi_sck, spi_mosi, spi_ss_n (in), spi_miso, spi_miso_oe (out)
//   TX stream    tx_data[7:0], tx_valid (in), tx_ready (out)
//   RX stream    rx_data[7:0], rx_valid (out), rx_ready (in)
//   Status       tx_underrun, rx_overrun (out, 1-cycle pulses)
interface k12a_spi_target_if;
    logic       spi_sck;
    logic       spi_mosi;
    logic       spi_ss_n;
    logic       spi_miso;
    logic       spi_miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       rx_ready;
    logic       tx_underrun;
    logic       rx_overrun;

    modport slave (
        input  spi_sck, spi_mosi, spi_ss_n, tx_data, tx_valid, rx_ready,
        output spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, rx_overrun
    );

    modport master (
        output spi_sck, spi_mosi, spi_ss_n, tx_data, tx_valid, rx_ready,
        input  spi_miso, spi_miso_oe, tx_ready, rx_data, rx_valid, tx_underrun, rx_overrun
    );
endinterface

// File: rtl/k12a_spi_target.sv
// rtl/k12a_spi_target.sv - SPI mode-0 target, oversampled in cpu_clock, byte valid/ready TX/RX
// Ports:
//   cpu_clock  block clock, rising edge
//   reset_n    asynchronous active-low reset
//   bus        k12a_spi_target_if.slave: SPI pins, TX/RX byte streams, underrun/overrun pulses
// Parameters:
//   SYNC_STAGES    synchroniser depth on sck/mosi/ss_n (>=2)
//   RX_FIFO_DEPTH  RX FIFO entries (power of two >=2), only with K12A_SPI_TARGET_RX_FIFO_EN
// Build option:
//   K12A_SPI_TARGET_RX_FIFO_EN  defined: RX storage is a FIFO; undefined: single holding register
module k12a_spi_target #(
    parameter int SYNC_STAGES   = 2,
    parameter int RX_FIFO_DEPTH = 4
) (
    input  logic               cpu_clock,
    input  logic               reset_n,
    k12a_spi_target_if.slave   bus
);
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("k12a_spi_target: SYNC_STAGES must be >= 2");
    end
    if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("k12a_spi_target: RX_FIFO_DEPTH must be a power of two >= 2");
    end

    typedef enum logic {ST_IDLE, ST_ACTIVE} state_t;

    state_t                 state;
    logic [SYNC_STAGES-1:0] sck_sync, mosi_sync, ss_sync;
    logic                   sck_q, ss_q;
    logic                   sck_s, mosi_s, ss_s;
    logic                   sck_rise, sck_fall, ss_fall, ss_rise;
    logic [2:0]             bit_cnt;
    logic [6:0]             rx_shift;
    logic [7:0]             tx_shift, tx_hold;
    logic                   tx_empty, miso_oe, tx_underrun_q, rx_overrun_q;
    logic                   load, push, pop;
    logic [7:0]             push_byte;
    logic [7:0]             rx_data_int;
    logic                   rx_valid_int;

    // Pins are asynchronous to cpu_clock; the timing budget guarantees every
    // phase outlasts the synchroniser, so edges are found by comparing the
    // synchronised level with its previous value.
    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            sck_sync  <= '0;
            mosi_sync <= '0;
            ss_sync   <= '1;
            sck_q     <= 1'b0;
            ss_q      <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], bus.spi_sck};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], bus.spi_mosi};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], bus.spi_ss_n};
            sck_q     <= sck_s;
            ss_q      <= ss_s;
        end
    end

    always_comb begin
        sck_s     = sck_sync[SYNC_STAGES-1];
        mosi_s    = mosi_sync[SYNC_STAGES-1];
        ss_s      = ss_sync[SYNC_STAGES-1];
        sck_rise  = sck_s & ~sck_q;
        sck_fall  = ~sck_s & sck_q;
        ss_fall   = ~ss_s & ss_q;
        ss_rise   = ss_s & ~ss_q;
        // Deselect wins over any sck edge seen in the same cycle.
        load      = (state == ST_IDLE && ss_fall) ||
                    (state == ST_ACTIVE && !ss_rise && sck_fall && bit_cnt == 3'd0);
        push      = (state == ST_ACTIVE) && !ss_rise && sck_rise && (bit_cnt == 3'd7);
        push_byte = {rx_shift, mosi_s};
        pop       = rx_valid_int & bus.rx_ready;
    end

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            state         <= ST_IDLE;
            bit_cnt       <= 3'd0;
            rx_shift      <= 7'd0;
            tx_shift      <= 8'hFF;
            tx_hold       <= 8'h00;
            tx_empty      <= 1'b1;
            miso_oe       <= 1'b0;
            tx_underrun_q <= 1'b0;
        end else begin
            tx_underrun_q <= 1'b0;

            // A byte written in the same cycle as a LOAD is not seen by that
            // LOAD: it only reaches tx_hold after this edge.
            if (load) begin
                if (!tx_empty) begin
                    tx_shift <= tx_hold;
                    tx_empty <= 1'b1;
                end else begin
                    tx_shift      <= 8'hFF;
                    tx_underrun_q <= 1'b1;
                end
            end else if (state == ST_ACTIVE && ss_rise) begin
                tx_shift <= 8'hFF;
            end else if (state == ST_ACTIVE && sck_fall) begin
                tx_shift <= {tx_shift[6:0], 1'b1};
            end

            // load empties the register only when full, the write fills it
            // only when empty, so the two never collide.
            if (bus.tx_valid && tx_empty) begin
                tx_hold  <= bus.tx_data;
                tx_empty <= 1'b0;
            end

            case (state)
                ST_IDLE: begin
                    if (ss_fall) begin
                        state   <= ST_ACTIVE;
                        miso_oe <= 1'b1;
                        bit_cnt <= 3'd0;
                    end
                end
                ST_ACTIVE: begin
                    if (ss_rise) begin
                        state   <= ST_IDLE;
                        miso_oe <= 1'b0;
                        bit_cnt <= 3'd0;
                    end else if (sck_rise) begin
                        rx_shift <= push_byte[6:0];
                        bit_cnt  <= bit_cnt + 3'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

`ifdef K12A_SPI_TARGET_RX_FIFO_EN
    localparam int AW = $clog2(RX_FIFO_DEPTH);

    logic [7:0]  rx_mem [RX_FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        rx_full;

    // Extra pointer bit distinguishes full (MSBs differ) from empty (equal).
    always_comb begin
        rx_full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
        rx_valid_int = (wr_ptr != rd_ptr);
        rx_data_int  = rx_mem[rd_ptr[AW-1:0]];
    end

    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < RX_FIFO_DEPTH; i++) rx_mem[i] <= 8'h00;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_overrun_q <= 1'b0;
            if (push) begin
                if (!rx_full || pop) begin
                    rx_mem[wr_ptr[AW-1:0]] <= push_byte;
                    wr_ptr                 <= wr_ptr + (AW+1)'(1);
                end else begin
                    rx_overrun_q <= 1'b1;
                end
            end
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
        end
    end
`else
    always_ff @(posedge cpu_clock or negedge reset_n) begin
        if (!reset_n) begin
            rx_data_int  <= 8'h00;
            rx_valid_int <= 1'b0;
            rx_overrun_q <= 1'b0;
        end else begin
            rx_overrun_q <= 1'b0;
            if (push) begin
                if (!rx_valid_int || pop) begin
                    rx_data_int  <= push_byte;
                    rx_valid_int <= 1'b1;
                end else begin
                    rx_overrun_q <= 1'b1;
                end
            end else if (pop) begin
                rx_valid_int <= 1'b0;
            end
        end
    end
`endif

    assign bus.spi_miso    = tx_shift[7];
    assign bus.spi_miso_oe = miso_oe;
    assign bus.tx_ready    = tx_empty;
    assign bus.rx_data     = rx_data_int;
    assign bus.rx_valid    = rx_valid_int;
    assign bus.tx_underrun = tx_underrun_q;
    assign bus.rx_overrun  = rx_overrun_q;
endmodule

// File: tb/tb_k12a_spi_target.sv
// tb/tb_k12a_spi_target.sv - directed bench for k12a_spi_target with a byte-level model
module tb_k12a_spi_target;
    localparam int H = 6;
`ifdef K12A_SPI_TARGET_RX_FIFO_EN
    localparam int DEPTH = 4;
`else
    localparam int DEPTH = 1;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    k12a_spi_target_if bus();

    k12a_spi_target #(.SYNC_STAGES(2), .RX_FIFO_DEPTH(4)) dut (
        .cpu_clock (clk),
        .reset_n   (rst_n),
        .bus       (bus)
    );

    int checks = 0;
    int failures = 0;
    int got_und = 0, got_ovr = 0, exp_und = 0, exp_ovr = 0, pop_cnt = 0;
    logic [7:0] last_pop = 8'h00;
    logic [7:0] rxq[$];
    logic [7:0] pend[$];
    logic [7:0] cur_tx = 8'hFF;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        repeat (n) tick();
    endtask

    // Model: every LOAD point hands the master the oldest pending TX byte or 0xFF.
    task automatic model_load();
        if (pend.size() > 0) cur_tx = pend.pop_front();
        else begin
            cur_tx = 8'hFF;
            exp_und++;
        end
    endtask

    task automatic model_push(input logic [7:0] b);
        if (rxq.size() < DEPTH) rxq.push_back(b);
        else exp_ovr++;
    endtask

    // Compare process: RX head and pulse counting on every falling clk edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.tx_underrun) got_und++;
            if (bus.rx_overrun) got_ovr++;
            if (bus.rx_valid) begin
                if (rxq.size() == 0) check("rx_valid_unexpected", 32'(bus.rx_valid), 0);
                else begin
                    check("rx_data_head", 32'(bus.rx_data), 32'(rxq[0]));
                    if (bus.rx_ready) begin
                        last_pop = rxq.pop_front();
                        pop_cnt++;
                    end
                end
            end
        end
    end

    task automatic tx_write(input logic [7:0] b);
        int n = 0;
        tick();
        while (!bus.tx_ready && n < 20) begin
            tick();
            n++;
        end
        if (!bus.tx_ready) check("tx_ready_timeout", 32'(bus.tx_ready), 1);
        else begin
            bus.tx_valid = 1'b1;
            bus.tx_data  = b;
            tick();
            bus.tx_valid = 1'b0;
            check("tx_ready_after_write", 32'(bus.tx_ready), 0);
            pend.push_back(b);
        end
    endtask

    task automatic frame_begin();
        bus.spi_ss_n = 1'b0;
        model_load();
        wait_ticks(H);
    endtask

    task automatic frame_end();
        wait_ticks(H);
        bus.spi_ss_n = 1'b1;
        bus.spi_mosi = 1'b0;
        wait_ticks(H + 4);
        check("underrun_count", 32'(got_und), 32'(exp_und));
        check("overrun_count", 32'(got_ovr), 32'(exp_ovr));
    endtask

    task automatic xfer_byte(input logic [7:0] mo, input bit lat_chk, output logic [7:0] got);
        for (int i = 7; i >= 0; i--) begin
            bus.spi_mosi = mo[i];
            wait_ticks(H);
            got[i] = bus.spi_miso;
            if (i == 7) check("miso_oe_active", 32'(bus.spi_miso_oe), 1);
            bus.spi_sck = 1'b1;
            if (i == 0) begin
                model_push(mo);
                if (lat_chk) begin
                    wait_ticks(2);
                    check("rx_latency_early", 32'(bus.rx_valid), 0);
                    tick();
                    check("rx_latency_on_time", 32'(bus.rx_valid), 1);
                    wait_ticks(H - 3);
                end else wait_ticks(H);
            end else wait_ticks(H);
            bus.spi_sck = 1'b0;
        end
        check("master_sampled", 32'(got), 32'(cur_tx));
        model_load();
    endtask

    task automatic partial_bits(input int n);
        for (int k = 0; k < n; k++) begin
            bus.spi_mosi = 1'b1;
            wait_ticks(H);
            bus.spi_sck = 1'b1;
            wait_ticks(H);
            bus.spi_sck = 1'b0;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] got;
        int base, pops;
        bus.spi_sck = 1'b0; bus.spi_mosi = 1'b0; bus.spi_ss_n = 1'b1;
        bus.tx_data = 8'h00; bus.tx_valid = 1'b0; bus.rx_ready = 1'b0;

        wait_ticks(3);
        check("rst_miso", 32'(bus.spi_miso), 1);
        check("rst_miso_oe", 32'(bus.spi_miso_oe), 0);
        check("rst_tx_ready", 32'(bus.tx_ready), 1);
        check("rst_rx_valid", 32'(bus.rx_valid), 0);
        check("rst_rx_data", 32'(bus.rx_data), 0);
        check("rst_underrun", 32'(bus.tx_underrun), 0);
        check("rst_overrun", 32'(bus.rx_overrun), 0);
        rst_n = 1'b1;
        wait_ticks(5);

        // 0x3C out, 0xA5 in, with RX latency probe
        tx_write(8'h3C);
        frame_begin();
        xfer_byte(8'hA5, 1'b1, got);
        frame_end();
        check("lit_master_3c", 32'(got), 32'h3C);
        check("lit_rx_a5", 32'(bus.rx_data), 32'hA5);
        check("lit_rx_valid_a5", 32'(bus.rx_valid), 1);
        check("lit_und_after_a5", 32'(exp_und), 1);
        bus.rx_ready = 1'b1;
        wait_ticks(4);
        check("rx_drained_a5", 32'(rxq.size()), 0);

        // underrun: no TX byte pending
        base = got_und;
        frame_begin();
        xfer_byte(8'h00, 1'b0, got);
        check("lit_underrun_once", 32'(got_und - base), 1);
        frame_end();
        check("lit_master_ff", 32'(got), 32'hFF);

        // two bytes with consumer stalled
        bus.rx_ready = 1'b0;
        frame_begin();
        xfer_byte(8'h11, 1'b0, got);
        xfer_byte(8'h22, 1'b0, got);
        frame_end();
        check("lit_rx_11_held", 32'(bus.rx_data), 32'h11);
`ifdef K12A_SPI_TARGET_RX_FIFO_EN
        check("lit_no_overrun", 32'(got_ovr), 0);
`else
        check("lit_one_overrun", 32'(got_ovr), 1);
`endif
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
`ifdef K12A_SPI_TARGET_RX_FIFO_EN
        check("lit_fifo_second_valid", 32'(bus.rx_valid), 1);
        check("lit_fifo_second_22", 32'(bus.rx_data), 32'h22);
`else
        check("lit_single_empty", 32'(bus.rx_valid), 0);
`endif
        bus.rx_ready = 1'b1;
        wait_ticks(6);
        check("rx_drained_11_22", 32'(rxq.size()), 0);

        // aborted partial frame, then full 0x81
        pops = pop_cnt;
        frame_begin();
        partial_bits(5);
        wait_ticks(H);
        bus.spi_ss_n = 1'b1;
        wait_ticks(H + 4);
        check("abort_no_push", 32'(pop_cnt - pops), 0);
        frame_begin();
        xfer_byte(8'h81, 1'b0, got);
        frame_end();
        check("lit_only_81_count", 32'(pop_cnt - pops), 1);
        check("lit_only_81_value", 32'(last_pop), 32'h81);

        // reset in the middle of a frame with RX and TX bytes held
        bus.rx_ready = 1'b0;
        frame_begin();
        xfer_byte(8'h44, 1'b0, got);
        frame_end();
        frame_begin();
        tx_write(8'h99);
        partial_bits(4);
        tick();
        rst_n = 1'b0;
        #1;
        check("mid_rst_miso", 32'(bus.spi_miso), 1);
        check("mid_rst_miso_oe", 32'(bus.spi_miso_oe), 0);
        check("mid_rst_tx_ready", 32'(bus.tx_ready), 1);
        check("mid_rst_rx_valid", 32'(bus.rx_valid), 0);
        check("mid_rst_rx_data", 32'(bus.rx_data), 0);
        check("mid_rst_pulses", 32'({bus.tx_underrun, bus.rx_overrun}), 0);
        rxq.delete();
        pend.delete();
        cur_tx = 8'hFF;
        bus.spi_ss_n = 1'b1;
        bus.spi_sck  = 1'b0;
        bus.spi_mosi = 1'b0;
        wait_ticks(3);
        rst_n = 1'b1;
        wait_ticks(5);
        bus.rx_ready = 1'b1;
        pops = pop_cnt;
        frame_begin();
        xfer_byte(8'h5A, 1'b0, got);
        frame_end();
        check("lit_after_rst_count", 32'(pop_cnt - pops), 1);
        check("lit_after_rst_5a", 32'(last_pop), 32'h5A);
        check("final_rx_drained", 32'(rxq.size()), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
